// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receiver: default bit timing, data width and FSM states.
package uart_rx_fifo_pkg;

    localparam int unsigned DefaultClksPerBit = 434;
    localparam int unsigned UartDataBits      = 8;

    typedef enum logic [1:0] {
        RxIdle  = 2'd0,
        RxStart = 2'd1,
        RxData  = 2'd2,
        RxStop  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_byte_fifo.sv
// Byte FIFO with registered read data; pointers carry one extra wrap bit.
module uart_rx_fifo_byte_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wrreq,
    input  logic [7:0] data,
    input  logic       rdreq,
    output logic [7:0] q,
    output logic       empty,
    output logic       full
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PtrOne = (DEPTH_LOG2 + 1)'(1);

    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]          q_q, q_d;
    logic [7:0]          mem_q [Depth];
    logic                rd_en, wr_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

    // A write into a full FIFO is taken only when a pop frees the slot in the same cycle.
    assign rd_en = rdreq && !empty;
    assign wr_en = wrreq && (!full || rd_en);
    assign q     = q_q;

    // Next-state for pointers and the registered read data.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        q_d      = q_q;
        if (rd_en) begin
            q_d      = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
    end

    // Pointer and read-data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            q_q      <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            q_q      <= q_d;
        end
    end

    // Storage array, intentionally without reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= data;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO, with frame-error pulse and sticky overrun flag.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
    parameter int unsigned DEPTH_LOG2   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rdreq,
    output logic [7:0] q,
    output logic       empty,
    output logic       full,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned      CntW     = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0]  HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0]  FullLoad = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0]  CntOne   = CntW'(1);
    localparam logic [2:0]       LastBit  = 3'(UartDataBits - 1);

    logic            sync1_q, sync2_q, rx_prev_q;
    logic            rx_s, fall;
    rx_state_e       state_q, state_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            push;

    assign rx_s      = sync2_q;
    assign fall      = !rx_s && rx_prev_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    // Two-flop synchronizer plus previous-sample register for start-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= rxd;
            sync2_q   <= sync1_q;
            rx_prev_q <= rx_s;
        end
    end

    // Receive FSM: sample each bit at its centre, push on a good stop bit.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        unique case (state_q)
            RxIdle: begin
                if (fall) begin
                    baud_d  = HalfLoad;
                    state_d = RxStart;
                end
            end
            RxStart: begin
                if (baud_q != '0) begin
                    baud_d = baud_q - CntOne;
                end else if (rx_s) begin
                    state_d = RxIdle;
                end else begin
                    baud_d    = FullLoad;
                    bit_idx_d = '0;
                    state_d   = RxData;
                end
            end
            RxData: begin
                if (baud_q != '0) begin
                    baud_d = baud_q - CntOne;
                end else begin
                    shreg_d = {rx_s, shreg_q[7:1]};
                    baud_d  = FullLoad;
                    if (bit_idx_q == LastBit) begin
                        state_d = RxStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            RxStop: begin
                if (baud_q != '0) begin
                    baud_d = baud_q - CntOne;
                end else begin
                    // Leaving at mid-stop so a back-to-back start edge is not missed.
                    push        = rx_s;
                    frame_err_d = !rx_s;
                    state_d     = RxIdle;
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    // While full the FIFO is non-empty, so rdreq alone decides whether the pop frees a slot.
    always_comb begin
        overrun_d = overrun_q | (push && full && !rdreq);
    end

    // FSM, counters, shift register and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RxIdle;
            baud_q      <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    uart_rx_fifo_byte_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .wrreq(push),
        .data (shreg_q),
        .rdreq(rdreq),
        .q    (q),
        .empty(empty),
        .full (full)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus a randomized phase, all checked
// against a queue-based model of the receiver and FIFO.
module tb_uart_rx_fifo;

    localparam int unsigned Cpb       = 16;
    localparam int unsigned DepthLog2 = 4;
    localparam int unsigned Depth     = 1 << DepthLog2;
    // Edge after the start drive at which the stop bit is sampled: two synchronizer flops and
    // the edge-detect register, half a bit to the start centre, then nine full bits.
    localparam int unsigned StopLat   = 3 + Cpb / 2 + 9 * Cpb;

    logic       clk = 1'b0;
    logic       rst, rxd, rdreq;
    logic [7:0] q;
    logic       empty, full, frame_err, overrun;

    uart_rx_fifo #(
        .CLKS_PER_BIT(Cpb),
        .DEPTH_LOG2  (DepthLog2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .rdreq    (rdreq),
        .q        (q),
        .empty    (empty),
        .full     (full),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pending stop-sample events plus a queue of stored bytes.
    typedef struct {
        int unsigned cyc;
        logic [7:0]  data;
        bit          good;
    } ev_t;

    ev_t         evq[$];
    logic [7:0]  mq[$];
    logic [7:0]  m_q   = 8'h00;
    bit          m_ovr = 1'b0;
    bit          m_ferr = 1'b0;
    int unsigned cyc   = 0;
    bit          chk_en = 1'b0;

    initial begin
        ev_t ev;
        bit  pop;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                mq.delete();
                evq.delete();
                m_q    = 8'h00;
                m_ovr  = 1'b0;
                m_ferr = 1'b0;
            end else begin
                pop    = rdreq && (mq.size() > 0);
                m_ferr = 1'b0;
                if (pop) m_q = mq.pop_front();
                if (evq.size() > 0 && evq[0].cyc == cyc) begin
                    ev = evq.pop_front();
                    if (!ev.good) m_ferr = 1'b1;
                    else if (mq.size() < Depth) mq.push_back(ev.data);
                    else m_ovr = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (chk_en && !rst) begin
            check("cyc_empty", empty, mq.size() == 0);
            check("cyc_full", full, mq.size() == Depth);
            check("cyc_q", q, m_q);
            check("cyc_overrun", overrun, m_ovr);
            check("cyc_frame_err", frame_err, m_ferr);
        end
    end

    // Observers used by the directed checks.
    int unsigned fall_cyc   = 0;
    int          ferr_cnt   = 0;
    logic        prev_empty = 1'b1;
    initial forever begin
        @(negedge clk);
        if (prev_empty && !empty) fall_cyc = cyc;
        prev_empty = empty;
        if (frame_err) ferr_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop_one();
        rdreq = 1'b1;
        idle(1);
        rdreq = 1'b0;
    endtask

    // Sends one frame starting now; abort_bit >= 0 pulses rst mid-way through that data bit.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int abort_bit,
                              output int unsigned start);
        ev_t ev;
        start   = cyc;
        ev.cyc  = start + StopLat;
        ev.data = b;
        ev.good = stop_ok;
        evq.push_back(ev);
        rxd = 1'b0;
        idle(Cpb);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            if (i == abort_bit) begin
                idle(Cpb / 2);
                rst = 1'b1;
                rxd = 1'b1;
                idle(1);
                rst = 1'b0;
                return;
            end
            idle(Cpb);
        end
        rxd = stop_ok;
        idle(Cpb);
        rxd = 1'b1;
        if (!stop_ok) idle(4);
    endtask

    initial begin
        int unsigned st;
        logic [7:0]  b;
        bit          ok;
        bit          rnd_done;
        rst   = 1'b1;
        rxd   = 1'b1;
        rdreq = 1'b0;
        idle(3);
        check("rst_q", q, 8'h00);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        rst = 1'b0;
        idle(2);
        chk_en = 1'b1;

        // Single frame, latency of empty, then pop.
        send_frame(8'hA5, 1'b1, -1, st);
        check("t1_empty_latency", fall_cyc - st, 155);
        check("t1_not_empty", empty, 1'b0);
        pop_one();
        check("t1_q", q, 8'hA5);
        check("t1_empty_after_pop", empty, 1'b1);

        // Short low glitch must be rejected, then a normal frame.
        rxd = 1'b0;
        idle(5);
        rxd = 1'b1;
        idle(30);
        check("t2_glitch_empty", empty, 1'b1);
        send_frame(8'h01, 1'b1, -1, st);
        pop_one();
        check("t2_q", q, 8'h01);

        // Bad stop bit.
        ferr_cnt = 0;
        send_frame(8'h3C, 1'b0, -1, st);
        idle(4);
        check("t3_ferr_pulses", ferr_cnt, 1);
        check("t3_empty", empty, 1'b1);
        check("t3_overrun", overrun, 1'b0);

        // Overfill by one, then drain in order.
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, -1, st);
        check("t4_full", full, 1'b1);
        check("t4_no_overrun_yet", overrun, 1'b0);
        send_frame(8'h10, 1'b1, -1, st);
        check("t4_overrun", overrun, 1'b1);
        check("t4_still_full", full, 1'b1);
        for (int i = 0; i < 16; i++) begin
            pop_one();
            check("t4_drain_q", q, 32'(i));
        end
        check("t4_empty", empty, 1'b1);
        check("t4_overrun_sticky", overrun, 1'b1);

        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);

        // Push into a full FIFO with a pop on the same edge.
        for (int i = 0; i < 16; i++) send_frame(8'h40 + 8'(i), 1'b1, -1, st);
        check("t5_full", full, 1'b1);
        fork
            send_frame(8'h50, 1'b1, -1, st);
            begin
                int unsigned t;
                t = cyc + StopLat;
                while (cyc != t - 1) idle(1);
                rdreq = 1'b1;
                idle(1);
                rdreq = 1'b0;
            end
        join
        check("t5_full_kept", full, 1'b1);
        check("t5_overrun", overrun, 1'b0);
        check("t5_q_oldest", q, 8'h40);

        // Reset in the middle of a frame, then a clean frame.
        send_frame(8'hF0, 1'b1, 3, st);
        check("t6_empty", empty, 1'b1);
        check("t6_q", q, 8'h00);
        check("t6_full", full, 1'b0);
        idle(5);
        send_frame(8'h5A, 1'b1, -1, st);
        pop_one();
        check("t6_q_after", q, 8'h5A);

        // Randomized frames, stop-bit errors, gaps and reads.
        rnd_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 24; k++) begin
                    b  = 8'($urandom);
                    ok = ($urandom_range(0, 5) != 0);
                    send_frame(b, ok, -1, st);
                    if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 40)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    rdreq = ($urandom_range(0, 5) == 0);
                    idle(1);
                end
                rdreq = 1'b0;
            end
        join
        for (int k = 0; k < 40 && mq.size() > 0; k++) pop_one();
        idle(2);
        check("final_empty", empty, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
